serial_result_tx: RTL and testbench

Bit-serial result transmitter: the output end of the accelerator's one-bit-per-cycle host link. The controller loads weights and inputs bit-serially; this block streams computed result words from the result memory back to the host, one bit per cycle. The command arrives on the same 32-bit `mode` bus. The block sits beside `controller` and reads the result memory through a one-cycle-latency read port.

---
 rtl/serial_result_tx_pkg.sv | 37 +++
 rtl/serial_result_tx_if.sv | 35 +++
 rtl/serial_result_tx_shifter.sv | 108 ++++++++++
 rtl/serial_result_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_serial_result_tx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/serial_result_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the bit-serial result transmitter:
//   - UNLOAD opcode and the bit positions of the fields in the 32-bit mode word
//   - transmitter FSM state encoding
//   - PARITY_EN, set when SERIAL_TX_PARITY_EN is defined: each word is then
//     followed by one even-parity bit
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam logic [3:0] OP_UNLOAD = 4'h2;

  // mode word field positions
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int DIR_BIT  = 11;
  localparam int CNT_MSB  = 10;
  localparam int CNT_LSB  = 4;
  localparam int ADDR_MSB = 3;
  localparam int ADDR_LSB = 0;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/serial_result_tx_if.sv
// -----------------------------------------------------------------------------
// serial_result_tx_if
// Bundles the transmitter's command, result-memory read port and serial output.
//   enable    : global run enable          mode      : 32-bit command word
//   rd_en     : memory read strobe         rd_addr   : memory read address
//   rd_data   : memory data (1-cycle lat.) out_data  : serial output bit
//   out_valid : out_data is payload        out_first : first bit of a word
//   busy      : transfer in progress       done      : completion pulse
// master = transmitter side, slave = host/memory side.
// -----------------------------------------------------------------------------
interface serial_result_tx_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 4
);
  logic              enable;
  logic [31:0]       mode;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              out_data;
  logic              out_valid;
  logic              out_first;
  logic              busy;
  logic              done;

  modport master (
    input  enable, mode, rd_data,
    output rd_en, rd_addr, out_data, out_valid, out_first, busy, done
  );

  modport slave (
    output enable, mode, rd_data,
    input  rd_en, rd_addr, out_data, out_valid, out_first, busy, done
  );
endinterface

// File: rtl/serial_result_tx_shifter.sv
// -----------------------------------------------------------------------------
// serial_tx_shifter
// Word shift register, frame bit counter and even-parity generator for the
// serial result transmitter. When SERIAL_TX_PARITY_EN is defined a frame is
// WORD_W data bits plus one parity bit, otherwise WORD_W data bits.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture word_in; its first bit is shown next cycle
//   step        : advance to the next bit of the current frame
//   msb_first   : shift direction for the word being sent
//   word_in     : word to load
//   bit_out     : registered current bit
//   first_out   : registered flag, current bit is bit 0 of the frame
//   frame_last  : current bit is the last bit of the frame
//   pf_hit      : the bit shown next cycle sits at the prefetch position
// -----------------------------------------------------------------------------
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              msb_first,
  input  logic [WORD_W-1:0] word_in,
  output logic              bit_out,
  output logic              first_out,
  output logic              frame_last,
  output logic              pf_hit
);

  localparam int FRAME_W = PARITY_EN ? WORD_W + 1 : WORD_W;
  // read for the next word goes out two bits before the frame ends, so its
  // data is ready exactly when the frame wraps
  localparam int PF_POS  = FRAME_W - 2;
  localparam int POS_W   = $clog2(FRAME_W);

  logic [WORD_W-1:0] sreg_r;
  logic [POS_W-1:0]  pos_r;
  logic              par_r;
  logic              bit_r;
  logic              first_r;

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    even_parity = ^w;
  endfunction

  function automatic logic head_bit(input logic [WORD_W-1:0] w, input logic msb);
    head_bit = msb ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w,
                                                  input logic msb);
    shift_word = msb ? {w[WORD_W-2:0], 1'b0} : {1'b0, w[WORD_W-1:1]};
  endfunction

  // frame position decode: last bit and prefetch position of the next cycle
  always_comb begin
    frame_last = (pos_r == POS_W'(FRAME_W - 1));
    pf_hit     = 1'b0;
    if (load) begin
      pf_hit = (PF_POS == 0);
    end else if (step) begin
      pf_hit = (PF_POS > 0) && (pos_r == POS_W'(PF_POS - 1));
    end else begin
      pf_hit = 1'b0;
    end
  end

  // shift register, bit counter and parity capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_r  <= '0;
      pos_r   <= '0;
      par_r   <= 1'b0;
      bit_r   <= 1'b0;
      first_r <= 1'b0;
    end else if (load) begin
      sreg_r  <= shift_word(word_in, msb_first);
      bit_r   <= head_bit(word_in, msb_first);
      pos_r   <= '0;
      first_r <= 1'b1;
      par_r   <= even_parity(word_in);
    end else if (step) begin
      pos_r   <= pos_r + POS_W'(1);
      first_r <= 1'b0;
      // after the last data bit the parity bit goes out (parity builds only)
      if (PARITY_EN && (pos_r == POS_W'(WORD_W - 1))) begin
        bit_r <= par_r;
      end else begin
        bit_r  <= head_bit(sreg_r, msb_first);
        sreg_r <= shift_word(sreg_r, msb_first);
      end
    end else begin
      sreg_r  <= sreg_r;
      pos_r   <= pos_r;
      par_r   <= par_r;
      bit_r   <= bit_r;
      first_r <= first_r;
    end
  end

  assign bit_out   = bit_r;
  assign first_out = first_r;

endmodule

// File: rtl/serial_result_tx.sv
// -----------------------------------------------------------------------------
// serial_result_tx
// Streams result words from the result memory to the host, one bit per cycle.
// An UNLOAD command (rising into opcode UNLOAD while enabled and idle) reads
// N words starting at the given address (wrapping modulo DEPTH) and shifts
// them out MSB- or LSB-first. Build option SERIAL_TX_PARITY_EN appends one
// even-parity bit to each word.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears every output
//   bus   : serial_result_tx_if.master (enable, mode, rd_en, rd_addr,
//           rd_data, out_data, out_valid, out_first, busy, done)
// -----------------------------------------------------------------------------
module serial_result_tx
  import serial_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  serial_result_tx_if.master bus
);

  tx_state_e         state_r;
  tx_state_e         next_state_s;
  logic [3:0]        prev_op_r;
  logic [6:0]        cnt_r;       // words left including the one on the wire
  logic              zero_r;      // current command had N = 0
  logic              msb_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_pend_r;   // memory data is valid this cycle
  logic [WORD_W-1:0] hold_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              done_r;

  logic [3:0]        op_s;
  logic [6:0]        n_s;
  logic              msb_s;
  logic [ADDR_W-1:0] start_s;
  logic              accept_s;
  logic              load_s;
  logic              step_s;
  logic              last_s;
  logic [6:0]        cnt_cur_s;
  logic              pf_issue_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic              zero_next_s;
  logic              busy_next_s;
  logic              done_next_s;
  logic [WORD_W-1:0] word_in_s;
  logic              bit_s;
  logic              first_s;
  logic              frame_last_s;
  logic              pf_hit_s;
  logic              unused_mode_s;

  assign op_s          = bus.mode[OP_MSB:OP_LSB];
  assign n_s           = bus.mode[CNT_MSB:CNT_LSB];
  assign msb_s         = bus.mode[DIR_BIT];
  assign start_s       = ADDR_W'(bus.mode[ADDR_MSB:ADDR_LSB]);
  assign unused_mode_s = ^bus.mode[31:16];

  assign accept_s = (state_r == IDLE) && bus.enable && (op_s == OP_UNLOAD) &&
                    (prev_op_r != OP_UNLOAD);

  // next-state and per-cycle shifter control; enable low freezes everything
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    if (bus.enable) begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (n_s == 7'd0) begin
              next_state_s = FIN;
            end else begin
              next_state_s = FETCH;
            end
          end else begin
            next_state_s = IDLE;
          end
        end
        FETCH: next_state_s = WAIT;
        WAIT: begin
          next_state_s = SHIFT;
          load_s       = 1'b1;
        end
        SHIFT: begin
          if (frame_last_s) begin
            if (cnt_r > 7'd1) begin
              load_s       = 1'b1;
              next_state_s = SHIFT;
            end else begin
              last_s       = 1'b1;
              next_state_s = FIN;
            end
          end else begin
            step_s       = 1'b1;
            next_state_s = SHIFT;
          end
        end
        FIN:     next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // prefetch decision, address wrap and status flags for the next cycle
  always_comb begin
    if ((state_r == SHIFT) && load_s) begin
      cnt_cur_s = cnt_r - 7'd1;
    end else begin
      cnt_cur_s = cnt_r;
    end
    pf_issue_s = pf_hit_s && (cnt_cur_s > 7'd1);

    if (rd_addr_r == ADDR_W'(DEPTH - 1)) begin
      addr_inc_s = '0;
    end else begin
      addr_inc_s = rd_addr_r + ADDR_W'(1);
    end

    if (accept_s) begin
      zero_next_s = (n_s == 7'd0);
    end else begin
      zero_next_s = zero_r;
    end

    case (next_state_s)
      FETCH, WAIT, SHIFT: busy_next_s = 1'b1;
      FIN:                busy_next_s = zero_next_s;  // N=0 is busy in FIN
      default:            busy_next_s = 1'b0;
    endcase

    done_next_s = last_s || ((state_r == FIN) && zero_r && bus.enable);

    // a read that landed during a frozen cycle lives in hold_r
    if (rd_pend_r) begin
      word_in_s = bus.rd_data;
    end else begin
      word_in_s = hold_r;
    end
  end

  // state, counters, read port and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      prev_op_r   <= OP_UNLOAD;  // a command held through reset must not start
      cnt_r       <= 7'd0;
      zero_r      <= 1'b0;
      msb_r       <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      rd_pend_r   <= 1'b0;
      hold_r      <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      prev_op_r <= op_s;
      rd_pend_r <= rd_en_r & bus.enable;
      if (rd_pend_r) begin
        hold_r <= bus.rd_data;
      end
      if (bus.enable) begin
        state_r <= next_state_s;
        zero_r  <= zero_next_s;
        if (accept_s) begin
          cnt_r     <= n_s;
          msb_r     <= msb_s;
          rd_addr_r <= start_s;
          rd_en_r   <= (n_s != 7'd0);
        end else begin
          cnt_r   <= cnt_cur_s;
          rd_en_r <= pf_issue_s;
          if (pf_issue_s) begin
            rd_addr_r <= addr_inc_s;
          end
        end
        out_valid_r <= (next_state_s == SHIFT);
        busy_r      <= busy_next_s;
        done_r      <= done_next_s;
      end
    end
  end

  serial_tx_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .step       (step_s),
    .msb_first  (msb_r),
    .word_in    (word_in_s),
    .bit_out    (bit_s),
    .first_out  (first_s),
    .frame_last (frame_last_s),
    .pf_hit     (pf_hit_s)
  );

  // frozen cycles carry no payload and issue no read
  assign bus.rd_en     = rd_en_r & bus.enable;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.out_valid = out_valid_r & bus.enable;
  assign bus.out_data  = bit_s & bus.out_valid;
  assign bus.out_first = first_s & bus.out_valid;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r & bus.enable;

endmodule

// File: tb/tb_serial_result_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_result_tx
// Scoreboard bench for serial_result_tx: each command pushes its expected bits
// and read addresses into queues; a negedge monitor pops and compares whenever
// the DUT presents out_valid or rd_en. Latency and done timing are checked in
// the command task. Define SERIAL_TX_PARITY_EN to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_serial_result_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk;
  logic reset;
  logic [7:0] mem [16];
  logic [1:0] exp_q[$];       // {bit, first}
  logic [3:0] exp_addr_q[$];
  int n_checks;
  int n_fail;

  serial_result_tx_if #(.WORD_W(8), .ADDR_W(4)) bus ();

  serial_result_tx #(.WORD_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // result memory with one-cycle read latency
  always @(posedge clk) begin
    if (reset) bus.rd_data <= 8'h00;
    else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bit: got out_valid=1 expected no payload at %0t", $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("payload_bit", {30'd0, bus.out_data, bus.out_first}, {30'd0, e});
        end
      end
      if (bus.rd_en === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_read: got rd_en=1 addr=%0h expected no read", bus.rd_addr);
        end else begin
          logic [3:0] a;
          a = exp_addr_q.pop_front();
          chk("rd_addr", {28'd0, bus.rd_addr}, {28'd0, a});
        end
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    chk(name, {19'd0, bus.rd_en, bus.rd_addr, bus.out_data, bus.out_valid,
               bus.out_first, bus.busy, bus.done}, 32'd0);
  endtask

  // issue one UNLOAD command, check latency, done timing and queue drain
  task automatic run_xfer(input logic msb, input int n, input int addr,
                          input int extra, input bit chk_lat);
    logic [31:0] cmd;
    logic [7:0]  w;
    logic [3:0]  a;
    logic        bv;
    int          done_at;
    cmd = {16'h0000, 4'h2, msb, 7'(n), 4'(addr)};
    for (int k = 0; k < n; k++) begin
      a = 4'((addr + k) % 16);
      exp_addr_q.push_back(a);
      w = mem[a];
      for (int b = 0; b < 8; b++) begin
        bv = msb ? w[7-b] : w[b];
        exp_q.push_back({bv, (b == 0)});
      end
`ifdef SERIAL_TX_PARITY_EN
      exp_q.push_back({^w, 1'b0});
`endif
    end
    bus.mode = 32'h0;
    repeat (2) @(posedge clk);
    #1 bus.mode = cmd;
    @(negedge clk);                   // cycle in which edge T samples cmd
    done_at = -1;
    for (int c = 1; c <= 400 && done_at < 0; c++) begin
      @(negedge clk);
      if (chk_lat && c == 1) begin
        chk("lat_busy_T1", {31'd0, bus.busy}, 32'd1);
        chk("lat_rd_en_T1", {31'd0, bus.rd_en}, {31'd0, (n != 0)});
      end
      if (chk_lat && c == 2 && n != 0) chk("lat_no_valid_T2", {31'd0, bus.out_valid}, 32'd0);
      if (chk_lat && c == 3 && n != 0) chk("lat_first_T3", {30'd0, bus.out_valid, bus.out_first}, 32'd3);
      if (bus.done === 1'b1) done_at = c;
    end
    chk("done_cycle", done_at, (n == 0) ? 2 : 3 + n * FRAME + extra);
    @(negedge clk);
    chk("done_pulse_end", {30'd0, bus.done, bus.busy}, 32'd0);
    chk("bits_drained", exp_q.size(), 0);
    chk("reads_drained", exp_addr_q.size(), 0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int act_cnt;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk);
    #1 reset = 1'b0;

    // N=1 MSB first from address 1: 0x11 -> 0,0,0,1,0,0,0,1
    run_xfer(1'b1, 1, 1, 0, 1'b1);
    // N=3 LSB first from address 4: 0x44, 0x55, 0x66 back to back
    run_xfer(1'b0, 3, 4, 0, 1'b1);
    // address wrap: 15 then 0 -> 0xFF, 0x00
    run_xfer(1'b1, 2, 15, 0, 1'b1);

    // enable low for 5 cycles in the middle of word 1 (0x88, 0x99 LSB first)
    fork
      run_xfer(1'b0, 2, 8, 5, 1'b1);
      begin
        repeat (16) @(posedge clk);
        #1 bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.enable = 1'b1;
      end
    join

    // reset during SHIFT with UNLOAD held: no restart until mode toggles
    for (int k = 0; k < 2; k++) begin
      exp_addr_q.push_back(4'(2 + k));
      for (int b = 0; b < 8; b++) exp_q.push_back({mem[2+k][7-b], (b == 0)});
    end
    bus.mode = 32'h0;
    repeat (2) @(posedge clk);
    #1 bus.mode = 32'h2822;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check_outputs_zero("reset_mid_shift");
    act_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.out_valid || bus.rd_en) act_cnt++;
    end
    chk("no_restart_held_cmd", act_cnt, 0);
    // N=0: busy at T+1, done at T+2, no reads or payload
    run_xfer(1'b0, 0, 0, 0, 1'b1);

`ifdef SERIAL_TX_PARITY_EN
    // 0x07 MSB first: 0,0,0,0,0,1,1,1 then parity 1
    mem[9] = 8'h07;
    run_xfer(1'b1, 1, 9, 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
